// File: rtl/main_mem_ctrl_pkg.sv
// main_mem_ctrl_pkg
//   Line geometry, FSM state encoding and address helpers for the main-memory
//   interface stage. The cache controller uses the same line geometry, so the
//   values here must match its view of a line.
//   Contents:
//     ADDR_W, WORD_W      byte address width and memory-bus word width
//     LINE_BYTES, LINE_W  cache line size in bytes and bits
//     BEATS, BEAT_W       words per line and width of the beat index
//     OFFSET_BITS         byte-offset bits inside a line
//     state_t             controller FSM states
//     line_base/word_addr/beat_addr  address alignment helpers
package main_mem_ctrl_pkg;

    localparam int ADDR_W      = 32;
    localparam int WORD_W      = 32;
    localparam int LINE_BYTES  = 64;
    localparam int LINE_W      = LINE_BYTES * 8;
    localparam int BEATS       = LINE_W / WORD_W;
    localparam int BEAT_W      = $clog2(BEATS);
    localparam int OFFSET_BITS = $clog2(LINE_BYTES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BEAT = 2'd1,
        WR_BEAT = 2'd2,
        RESP    = 2'd3
    } state_t;

    // Line-aligned base address of the line containing byte address a.
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
        return a & ~((ADDR_W'(1) << OFFSET_BITS) - ADDR_W'(1));
    endfunction

    // Word-aligned address of the word containing byte address a.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction

    // Beat address inside a line. The base has zero offset bits, so OR-ing in
    // the word offset is an add that can never carry into the line number.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [BEAT_W-1:0] beat);
        return base | (ADDR_W'(beat) << 2);
    endfunction

endpackage

// File: rtl/main_mem_ctrl_if.sv
// main_mem_ctrl_if
//   Bundles the cache-side request/response signals and the 32-bit memory bus
//   of the main-memory interface stage.
//   Modports:
//     slave   the controller: takes requests and bus acks, drives the line,
//             ready/err/protocol_err and the bus request/address/data
//     master  the environment: the cache controller plus the memory bus
//   Signals:
//     main_mem_addr/data_out/read_req/write_req   request from the cache
//     main_mem_data_in/ready/err, protocol_err     response to the cache
//     bus_req/we/addr/wdata, bus_ack/rdata         memory bus
interface main_mem_ctrl_if
    import main_mem_ctrl_pkg::*;
;
    logic [ADDR_W-1:0] main_mem_addr;
    logic [WORD_W-1:0] main_mem_data_out;
    logic              main_mem_read_req;
    logic              main_mem_write_req;
    logic [LINE_W-1:0] main_mem_data_in;
    logic              main_mem_ready;
    logic              main_mem_err;
    logic              protocol_err;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [WORD_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [WORD_W-1:0] bus_rdata;

    modport slave (
        input  main_mem_addr, main_mem_data_out, main_mem_read_req, main_mem_write_req,
        output main_mem_data_in, main_mem_ready, main_mem_err, protocol_err,
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport master (
        output main_mem_addr, main_mem_data_out, main_mem_read_req, main_mem_write_req,
        input  main_mem_data_in, main_mem_ready, main_mem_err, protocol_err,
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/main_mem_ctrl_line_assembler.sv
// main_mem_ctrl_line_assembler
//   Holds the cache line being assembled from read beats.
//   Ports:
//     clk, rst   clock and synchronous active-high reset (clears the line)
//     clr        zero the whole line (used when beat 0 of a new read lands)
//     we, sel    write wdata into word sel
//     wdata      word to store
//     line       assembled line, word k at bits [WORD_W*k +: WORD_W]
module main_mem_ctrl_line_assembler
    import main_mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [BEAT_W-1:0] sel,
    input  logic [WORD_W-1:0] wdata,
    output logic [LINE_W-1:0] line
);

    // A clear and a write in the same cycle leave only the written word,
    // because the word write is scheduled after the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            line <= '0;
        end else begin
            if (clr) begin
                line <= '0;
            end
            for (int k = 0; k < BEATS; k++) begin
                if (we && (sel == BEAT_W'(k))) begin
                    line[k*WORD_W +: WORD_W] <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl
//   Main-memory interface stage below the write-through cache controller.
//   A read pulse becomes a 16-beat word burst whose data is assembled into a
//   512-bit line; a write pulse becomes one word write. Each completion gives a
//   one-cycle main_mem_ready, with main_mem_err=1 if a beat timed out.
//   Ports:
//     clk, rst   clock and synchronous active-high reset
//     mem        main_mem_ctrl_if.slave (cache request/response + memory bus)
//   Parameters:
//     TIMEOUT    stall cycles one beat may spend waiting for bus_ack (>=1)
module main_mem_ctrl
    import main_mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    main_mem_ctrl_if.slave mem
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    state_t             state;
    logic [ADDR_W-1:0]  base;
    logic [BEAT_W-1:0]  beat;
    logic [TIMER_W-1:0] timer;
    logic               beat_store;
    logic               line_clr;
    logic               last_beat;
    logic               timed_out;
    logic               done;

    // Beats are stored in the same edge that sees the ack, so the line is
    // complete in the ready cycle. Beat 0 wipes the previous line so that an
    // aborted read leaves unreceived words at zero.
    assign beat_store = (state == RD_BEAT) && mem.bus_ack;
    assign line_clr   = beat_store && (beat == '0);
    assign last_beat  = (beat == BEAT_W'(BEATS - 1));

    // The stall cycle that brings the timer to TIMEOUT aborts the beat.
    assign timed_out  = !mem.bus_ack && (timer == TIMER_W'(TIMEOUT - 1));

    assign done = ((state == RD_BEAT) && mem.bus_ack && last_beat)
               || ((state == WR_BEAT) && mem.bus_ack)
               || (((state == RD_BEAT) || (state == WR_BEAT)) && timed_out);

    main_mem_ctrl_line_assembler u_line (
        .clk   (clk),
        .rst   (rst),
        .clr   (line_clr),
        .we    (beat_store),
        .sel   (beat),
        .wdata (mem.bus_rdata),
        .line  (mem.main_mem_data_in)
    );

    // Single FSM with registered bus and response outputs. Completion of any
    // transfer (last beat, write ack or timeout) is handled after the case so
    // that it overrides the per-state updates in one place.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            base               <= '0;
            beat               <= '0;
            timer              <= '0;
            mem.bus_req        <= 1'b0;
            mem.bus_we         <= 1'b0;
            mem.bus_addr       <= '0;
            mem.bus_wdata      <= '0;
            mem.main_mem_ready <= 1'b0;
            mem.main_mem_err   <= 1'b0;
            mem.protocol_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    beat  <= '0;
                    timer <= '0;
                    if (mem.main_mem_read_req) begin
                        base         <= line_base(mem.main_mem_addr);
                        mem.bus_req  <= 1'b1;
                        mem.bus_we   <= 1'b0;
                        mem.bus_addr <= line_base(mem.main_mem_addr);
                        state        <= RD_BEAT;
                        if (mem.main_mem_write_req) begin
                            mem.protocol_err <= 1'b1;
                        end
                    end else if (mem.main_mem_write_req) begin
                        mem.bus_req   <= 1'b1;
                        mem.bus_we    <= 1'b1;
                        mem.bus_addr  <= word_addr(mem.main_mem_addr);
                        mem.bus_wdata <= mem.main_mem_data_out;
                        state         <= WR_BEAT;
                    end
                end
                RD_BEAT: begin
                    if (mem.bus_ack) begin
                        timer <= '0;
                        if (!last_beat) begin
                            beat         <= beat + BEAT_W'(1);
                            mem.bus_addr <= beat_addr(base, beat + BEAT_W'(1));
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                WR_BEAT: begin
                    if (!mem.bus_ack) begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                RESP: begin
                    mem.main_mem_ready <= 1'b0;
                    mem.main_mem_err   <= 1'b0;
                    state              <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (done) begin
                mem.bus_req        <= 1'b0;
                mem.bus_we         <= 1'b0;
                mem.bus_addr       <= '0;
                mem.bus_wdata      <= '0;
                mem.main_mem_ready <= 1'b1;
                mem.main_mem_err   <= timed_out;
                timer              <= '0;
                state              <= RESP;
            end

            if ((state != IDLE) && (mem.main_mem_read_req || mem.main_mem_write_req)) begin
                mem.protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// tb_main_mem_ctrl
//   Directed bench for main_mem_ctrl. A responsive memory model answers bus
//   beats (word at byte X holds X) with configurable stalls; expected beats
//   and ready responses are queued when a request is driven and popped when
//   the DUT produces them.
module tb_main_mem_ctrl;
    import main_mem_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;

    main_mem_ctrl_if mem ();

    main_mem_ctrl #(.TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .mem (mem.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic              is_read;
        logic              err;
        logic [LINE_W-1:0] line;
    } resp_t;

    beat_t beat_q[$];
    resp_t resp_q[$];
    beat_t exp_beat;
    resp_t exp_resp;

    int vectors     = 0;
    int miscompares = 0;

    int stall_min    = 0;
    int stall_max    = 0;
    int ack_limit    = 1000;
    int acks_given   = 0;
    int wait_cnt     = 0;
    int stall_target = 0;
    bit new_beat     = 1'b1;
    bit monitor_on   = 1'b0;

    logic        prev_req   = 1'b0;
    logic        prev_ack   = 1'b0;
    logic        prev_we    = 1'b0;
    logic [31:0] prev_addr  = '0;
    logic [31:0] prev_wdata = '0;

    int lat;
    int req_cycles;
    int n;

    task automatic check_output(input string tag, input logic [LINE_W-1:0] observed,
                                input logic [LINE_W-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Queue the bus beats and (optionally) the ready response of a read.
    task automatic expect_read(input logic [31:0] base, input int nwords,
                               input logic err, input bit with_resp);
        resp_t r;
        beat_t b;
        r.is_read = 1'b1;
        r.err     = err;
        r.line    = '0;
        for (int k = 0; k < nwords; k++) begin
            b.addr  = base + 32'(4 * k);
            b.we    = 1'b0;
            b.wdata = '0;
            beat_q.push_back(b);
            r.line[k*32 +: 32] = base + 32'(4 * k);
        end
        if (with_resp) resp_q.push_back(r);
    endtask

    task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
        resp_t r;
        beat_t b;
        b.addr  = addr;
        b.we    = 1'b1;
        b.wdata = data;
        beat_q.push_back(b);
        r.is_read = 1'b0;
        r.err     = 1'b0;
        r.line    = '0;
        resp_q.push_back(r);
    endtask

    // One-cycle request pulse; returns at the negedge of the first cycle after it.
    task automatic apply_stimulus(input logic rd, input logic wr,
                                  input logic [31:0] addr, input logic [31:0] data);
        mem.main_mem_read_req  = rd;
        mem.main_mem_write_req = wr;
        mem.main_mem_addr      = addr;
        mem.main_mem_data_out  = data;
        check_output("no_ready_in_req_cycle", mem.main_mem_ready, 0);
        @(negedge clk);
        mem.main_mem_read_req  = 1'b0;
        mem.main_mem_write_req = 1'b0;
    endtask

    // Counts cycles from the first post-request cycle (1) to the ready cycle.
    task automatic wait_ready(input int budget, output int cycles, output int reqs);
        cycles = 1;
        reqs   = 0;
        while (mem.main_mem_ready !== 1'b1 && cycles < budget) begin
            if (mem.bus_req === 1'b1) reqs++;
            @(negedge clk);
            cycles++;
        end
        if (mem.main_mem_ready !== 1'b1) check_output("ready_timeout", mem.main_mem_ready, 1);
    endtask

    // Memory model: acks each beat after a stall, checks beats against the
    // queue, and checks that the bus is held stable while stalled and is zero
    // while idle.
    always @(negedge clk) begin
        if (mem.bus_req === 1'b1 && acks_given < ack_limit) begin
            if (new_beat) begin
                stall_target = $urandom_range(stall_max, stall_min);
                wait_cnt     = 0;
                new_beat     = 1'b0;
            end
            if (wait_cnt >= stall_target) begin
                mem.bus_ack   = 1'b1;
                mem.bus_rdata = mem.bus_we ? 32'h0 : mem.bus_addr;
                acks_given++;
                new_beat = 1'b1;
                if (beat_q.size() == 0) begin
                    check_output("spurious_beat", mem.bus_req, 0);
                end else begin
                    exp_beat = beat_q.pop_front();
                    check_output("beat_addr", mem.bus_addr, exp_beat.addr);
                    check_output("beat_we", mem.bus_we, exp_beat.we);
                    if (exp_beat.we) check_output("beat_wdata", mem.bus_wdata, exp_beat.wdata);
                end
            end else begin
                mem.bus_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem.bus_ack = 1'b0;
            if (mem.bus_req !== 1'b1) new_beat = 1'b1;
        end
        if (monitor_on) begin
            if (prev_req && !prev_ack && mem.bus_req === 1'b1)
                check_output("hold_stable", {mem.bus_addr, mem.bus_we, mem.bus_wdata},
                             {prev_addr, prev_we, prev_wdata});
            if (mem.bus_req !== 1'b1)
                check_output("idle_bus_zero", {mem.bus_addr, mem.bus_we, mem.bus_wdata}, 0);
        end
        prev_req   = (mem.bus_req === 1'b1);
        prev_ack   = mem.bus_ack;
        prev_addr  = mem.bus_addr;
        prev_we    = mem.bus_we;
        prev_wdata = mem.bus_wdata;
    end

    // Ready monitor: every ready pulse must match the oldest queued response.
    always @(negedge clk) begin
        if (mem.main_mem_ready === 1'b1) begin
            if (resp_q.size() == 0) begin
                check_output("spurious_ready", mem.main_mem_ready, 0);
            end else begin
                exp_resp = resp_q.pop_front();
                check_output("ready_err", mem.main_mem_err, exp_resp.err);
                if (exp_resp.is_read) check_output("ready_line", mem.main_mem_data_in, exp_resp.line);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst                    = 1'b1;
        mem.main_mem_addr      = '0;
        mem.main_mem_data_out  = '0;
        mem.main_mem_read_req  = 1'b0;
        mem.main_mem_write_req = 1'b0;
        mem.bus_ack            = 1'b0;
        mem.bus_rdata          = '0;
        repeat (3) @(negedge clk);
        check_output("rst_bus_req", mem.bus_req, 0);
        check_output("rst_ready", mem.main_mem_ready, 0);
        check_output("rst_err", mem.main_mem_err, 0);
        check_output("rst_protocol_err", mem.protocol_err, 0);
        check_output("rst_data_in", mem.main_mem_data_in, 0);
        check_output("rst_bus_addr", {mem.bus_addr, mem.bus_we, mem.bus_wdata}, 0);
        rst        = 1'b0;
        monitor_on = 1'b1;
        @(negedge clk);

        $display("[TB] read burst, zero-wait ack");
        expect_read(32'h0000_1200, 16, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 32'h0000_1234, 32'h0);
        wait_ready(100, lat, req_cycles);
        check_output("rd_latency", lat, 17);
        check_output("rd_req_cycles", req_cycles, 16);
        check_output("rd_word0", mem.main_mem_data_in[31:0], 32'h0000_1200);
        check_output("rd_word15", mem.main_mem_data_in[511:480], 32'h0000_123C);
        @(negedge clk);
        check_output("ready_one_cycle", mem.main_mem_ready, 0);

        $display("[TB] write with 3 wait cycles");
        stall_min = 3;
        stall_max = 3;
        expect_write(32'h0000_2004, 32'hDEAD_BEEF);
        apply_stimulus(1'b0, 1'b1, 32'h0000_2007, 32'hDEAD_BEEF);
        check_output("wr_bus_we", mem.bus_we, 1);
        check_output("wr_bus_addr", mem.bus_addr, 32'h0000_2004);
        wait_ready(100, lat, req_cycles);
        check_output("wr_latency", lat, 5);
        check_output("wr_req_cycles", req_cycles, 4);
        @(negedge clk);

        $display("[TB] read with dead bus after beat 5");
        stall_min  = 0;
        stall_max  = 0;
        ack_limit  = 6;
        acks_given = 0;
        expect_read(32'h0000_3000, 6, 1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b0, 32'h0000_3000, 32'h0);
        wait_ready(100, lat, req_cycles);
        check_output("to_latency", lat, 15);
        check_output("to_req_cycles", req_cycles, 14);
        check_output("to_word5", mem.main_mem_data_in[191:160], 32'h0000_3014);
        check_output("to_word6", mem.main_mem_data_in[223:192], 32'h0);
        @(negedge clk);
        ack_limit  = 1000;
        acks_given = 0;
        expect_read(32'h0000_3100, 16, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 32'h0000_3100, 32'h0);
        wait_ready(100, lat, req_cycles);
        check_output("after_to_latency", lat, 17);
        @(negedge clk);

        $display("[TB] simultaneous read+write, then repeated read");
        check_output("perr_before", mem.protocol_err, 0);
        expect_read(32'h0000_4040, 16, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b1, 32'h0000_4040, 32'h1111_1111);
        check_output("perr_both", mem.protocol_err, 1);
        @(negedge clk);
        apply_stimulus(1'b1, 1'b0, 32'h0000_4080, 32'h0);
        wait_ready(100, lat, req_cycles);
        repeat (4) @(negedge clk);
        check_output("perr_sticky", mem.protocol_err, 1);
        check_output("perr_resp_q_empty", resp_q.size(), 0);
        check_output("perr_beat_q_empty", beat_q.size(), 0);

        $display("[TB] reset during beat 9");
        expect_read(32'h0000_5000, 10, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h0000_5000, 32'h0);
        n = 0;
        while (mem.bus_addr !== 32'h0000_5024 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_output("beat9_reached", mem.bus_addr, 32'h0000_5024);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("mid_rst_bus_req", mem.bus_req, 0);
        check_output("mid_rst_ready", mem.main_mem_ready, 0);
        check_output("mid_rst_data_in", mem.main_mem_data_in, 0);
        check_output("mid_rst_perr", mem.protocol_err, 0);
        check_output("mid_rst_fsm_idle", dut.state, IDLE);
        @(negedge clk);
        expect_read(32'h0000_6000, 16, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 32'h0000_6000, 32'h0);
        wait_ready(100, lat, req_cycles);
        check_output("after_rst_latency", lat, 17);
        @(negedge clk);

        $display("[TB] top-of-memory read with random stalls");
        stall_min = 0;
        stall_max = 3;
        expect_read(32'hFFFF_FFC0, 16, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 32'hFFFF_FFC0, 32'h0);
        wait_ready(200, lat, req_cycles);
        check_output("top_word0", mem.main_mem_data_in[31:0], 32'hFFFF_FFC0);
        check_output("top_word15", mem.main_mem_data_in[511:480], 32'hFFFF_FFFC);

        repeat (3) @(negedge clk);
        check_output("final_resp_q_empty", resp_q.size(), 0);
        check_output("final_beat_q_empty", beat_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
